// File: rtl/ikascc_mapper_plus.sv
// rtl/ikascc_mapper_plus.sv - SCC/SCC+ cartridge bus front-end and bank mapper
module ikascc_mapper_plus #(
    parameter int BANK_BITS   = 6,
    parameter int SYNC_STAGES = 2,
    parameter int ENABLE_PLUS = 1
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST_n,
    input  logic                 i_MCLK_PCEN_n,
    input  logic                 i_CS_n,
    input  logic                 i_RD_n,
    input  logic                 i_WR_n,
    input  logic [15:0]          i_AB,
    input  logic [7:0]           i_DB,
    output logic                 o_ROMCS_n,
    output logic [BANK_BITS-1:0] o_ROMADDR,
    output logic                 o_RAMWE_n,
    output logic                 o_SCCREG_EN,
    output logic                 o_SCCPLUS_EN,
    output logic                 o_RDRQ,
    output logic                 o_WRRQ,
    output logic                 o_DB_OE,
    output logic [7:0]           o_MODE
);

    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [7:0]             bank [0:3];
    logic [7:0]             mode;
    logic [3:0]             ram;
    logic [1:0]             p;
    logic [7:0]             bank_sel;
    logic                   in_range;
    logic                   sccwin;
    logic                   pluswin;
    logic                   mem_ok;
    logic                   wrrq;
    logic                   mode_hit;
    logic                   bank_hit;

    // Chains idle at 1 so that reset release never looks like a fresh strobe edge.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            wr_sync <= '1;
            cs_sync <= '1;
        end else if (!i_MCLK_PCEN_n) begin
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], i_CS_n | i_WR_n};
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], i_CS_n};
        end
    end

    assign wrrq   = i_RST_n & ~i_MCLK_PCEN_n & wr_sync[SYNC_STAGES-1] & ~wr_sync[SYNC_STAGES-2];
    assign o_WRRQ = wrrq;
    assign o_RDRQ = i_RST_n & ~cs_sync[SYNC_STAGES-1];

    assign p         = {i_AB[15], i_AB[13]};
    assign in_range  = i_AB[15] ^ i_AB[14];
    assign bank_sel  = bank[p];
    assign o_ROMADDR = bank_sel[BANK_BITS-1:0];

    assign ram = {mode[4], mode[4] | mode[2], mode[4] | mode[1], mode[4] | mode[0]};

    assign sccwin  = ~mode[5] & (bank[2][5:0] == 6'h3F) & (i_AB[15:11] == 5'b10011);
    assign pluswin = mode[5] & bank[3][7] & (i_AB[15:11] == 5'b10111);

    assign o_SCCREG_EN  = sccwin;
    assign o_SCCPLUS_EN = pluswin;

    assign mode_hit = wrrq & (i_AB[15:1] == 15'h5FFF) & (ENABLE_PLUS != 0) & ~ram[3];
    assign bank_hit = wrrq & in_range & (i_AB[12:11] == 2'b10) & ~ram[p];

    // Full 8-bit bank values are stored: window decode looks at bits above BANK_BITS.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            bank[0] <= 8'd0;
            bank[1] <= 8'd1;
            bank[2] <= 8'd2;
            bank[3] <= 8'd3;
            mode    <= 8'h00;
        end else if (mode_hit) begin
            mode <= i_DB;
        end else if (bank_hit) begin
            bank[p] <= i_DB;
        end
    end

    assign o_MODE = mode;

    assign mem_ok    = ~i_CS_n & in_range & ~sccwin & ~pluswin;
    assign o_ROMCS_n = ~(mem_ok & (~i_RD_n | (~i_WR_n & ram[p])));
    assign o_RAMWE_n = ~(mem_ok & ~i_WR_n & ram[p]);
    assign o_DB_OE   = ~i_CS_n & ~i_RD_n &
                       ((sccwin & ~i_AB[7]) | (pluswin & (i_AB[7:5] != 3'b111)));

endmodule

// File: tb/tb_ikascc_mapper_plus.sv
// tb/tb_ikascc_mapper_plus.sv - table-driven self-checking bench for ikascc_mapper_plus
module tb_ikascc_mapper_plus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcen_n = 1'b1;
    logic        cs_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [15:0] ab = 16'h0000;
    logic [7:0]  db = 8'h00;
    logic        div_mode = 1'b1;

    logic       romcs_n0, ramwe_n0, scc0, plus0, rdrq0, wrrq0, dboe0;
    logic [5:0] romaddr0;
    logic [7:0] mode0;
    logic       romcs_n1, ramwe_n1, scc1, plus1, rdrq1, wrrq1, dboe1;
    logic [5:0] romaddr1;
    logic [7:0] mode1;

    ikascc_mapper_plus #(.BANK_BITS(6), .SYNC_STAGES(2), .ENABLE_PLUS(1)) u0 (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_MCLK_PCEN_n(pcen_n),
        .i_CS_n(cs_n), .i_RD_n(rd_n), .i_WR_n(wr_n), .i_AB(ab), .i_DB(db),
        .o_ROMCS_n(romcs_n0), .o_ROMADDR(romaddr0), .o_RAMWE_n(ramwe_n0),
        .o_SCCREG_EN(scc0), .o_SCCPLUS_EN(plus0), .o_RDRQ(rdrq0), .o_WRRQ(wrrq0),
        .o_DB_OE(dboe0), .o_MODE(mode0));

    ikascc_mapper_plus #(.BANK_BITS(6), .SYNC_STAGES(2), .ENABLE_PLUS(0)) u1 (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_MCLK_PCEN_n(pcen_n),
        .i_CS_n(cs_n), .i_RD_n(rd_n), .i_WR_n(wr_n), .i_AB(ab), .i_DB(db),
        .o_ROMCS_n(romcs_n1), .o_ROMADDR(romaddr1), .o_RAMWE_n(ramwe_n1),
        .o_SCCREG_EN(scc1), .o_SCCPLUS_EN(plus1), .o_RDRQ(rdrq1), .o_WRRQ(wrrq1),
        .o_DB_OE(dboe1), .o_MODE(mode1));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            pcen_n = div_mode ? ~pcen_n : 1'b0;
        end
    end

    typedef struct {
        bit         wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [5:0]  romaddr;
        logic        romcs_n;
        logic        ramwe_n;
        logic        scc;
        logic        plus;
        logic        dboe;
        logic [7:0]  mode;
    } vec_t;

    vec_t tbl [17];
    vec_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            output int pulses, output logic we_n);
        @(negedge clk);
        ab = a; db = d; cs_n = 1'b0; wr_n = 1'b0;
        pulses = 0;
        #2 we_n = ramwe_n0;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) #2;
            if (wrrq0) pulses++;
            @(negedge clk);
        end
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_read(input logic [15:0] a, output vec_t got, output logic rdrq);
        @(negedge clk);
        ab = a; cs_n = 1'b0; rd_n = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        got.romaddr = romaddr0; got.romcs_n = romcs_n0; got.ramwe_n = ramwe_n0;
        got.scc = scc0; got.plus = plus0; got.dboe = dboe0; got.mode = mode0;
        rdrq = rdrq0;
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    function automatic vec_t mk(bit w, logic [15:0] a, logic [7:0] d, logic [5:0] ra,
                                logic cs, logic we, logic s, logic pl, logic oe, logic [7:0] m);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.romaddr = ra; v.romcs_n = cs; v.ramwe_n = we;
        v.scc = s; v.plus = pl; v.dboe = oe; v.mode = m;
        return v;
    endfunction

    initial begin
        vec_t exp, got;
        int   pulses;
        logic we_n, rdrq;

        tbl[0]  = mk(0, 16'h4000, 8'h00, 6'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[1]  = mk(0, 16'h6000, 8'h00, 6'h01, 0, 1, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 16'h8000, 8'h00, 6'h02, 0, 1, 0, 0, 0, 8'h00);
        tbl[3]  = mk(0, 16'hA000, 8'h00, 6'h03, 0, 1, 0, 0, 0, 8'h00);
        tbl[4]  = mk(1, 16'h9000, 8'h3F, 6'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[5]  = mk(0, 16'h9810, 8'h00, 6'h3F, 1, 1, 1, 0, 1, 8'h00);
        tbl[6]  = mk(0, 16'h98A0, 8'h00, 6'h3F, 1, 1, 1, 0, 0, 8'h00);
        tbl[7]  = mk(1, 16'hBFFE, 8'h20, 6'h00, 0, 1, 0, 0, 0, 8'h20);
        tbl[8]  = mk(1, 16'hB000, 8'h80, 6'h00, 0, 1, 0, 0, 0, 8'h20);
        tbl[9]  = mk(0, 16'hB8E0, 8'h00, 6'h00, 1, 1, 0, 1, 0, 8'h20);
        tbl[10] = mk(0, 16'hB8C0, 8'h00, 6'h00, 1, 1, 0, 1, 1, 8'h20);
        tbl[11] = mk(0, 16'h9810, 8'h00, 6'h3F, 0, 1, 0, 0, 0, 8'h20);
        tbl[12] = mk(1, 16'hBFFE, 8'h10, 6'h00, 0, 1, 0, 0, 0, 8'h10);
        tbl[13] = mk(1, 16'h5000, 8'h55, 6'h00, 0, 0, 0, 0, 0, 8'h10);
        tbl[14] = mk(0, 16'h4000, 8'h00, 6'h00, 0, 1, 0, 0, 0, 8'h10);
        tbl[15] = mk(1, 16'hBFFE, 8'h00, 6'h00, 0, 0, 0, 0, 0, 8'h10);
        tbl[16] = mk(0, 16'hA000, 8'h00, 6'h00, 0, 1, 0, 0, 0, 8'h10);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_wrrq", wrrq0, 0);
        chk("reset_rdrq", rdrq0, 0);
        chk("reset_mode", mode0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            sb.push_back(tbl[i]);
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, pulses, we_n);
                exp = sb.pop_front();
                chk($sformatf("v%0d_wrrq_pulses", i), pulses, 1);
                chk($sformatf("v%0d_ramwe_n", i), we_n, exp.ramwe_n);
            end else begin
                do_read(tbl[i].addr, got, rdrq);
                exp = sb.pop_front();
                chk($sformatf("v%0d_romaddr", i), got.romaddr, exp.romaddr);
                chk($sformatf("v%0d_romcs_n", i), got.romcs_n, exp.romcs_n);
                chk($sformatf("v%0d_ramwe_n", i), got.ramwe_n, exp.ramwe_n);
                chk($sformatf("v%0d_sccreg", i), got.scc, exp.scc);
                chk($sformatf("v%0d_sccplus", i), got.plus, exp.plus);
                chk($sformatf("v%0d_db_oe", i), got.dboe, exp.dboe);
                chk($sformatf("v%0d_rdrq", i), rdrq, 1);
            end
            chk($sformatf("v%0d_mode", i), mode0, exp.mode);
            chk($sformatf("v%0d_mode_noplus", i), mode1, 8'h00);
        end

        // Full-rate enable: one pulse per access, bank update visible on read.
        div_mode = 1'b0;
        do_reset();
        do_write(16'h9000, 8'h15, pulses, we_n);
        chk("fullrate_pulses", pulses, 1);
        do_read(16'h8000, got, rdrq);
        chk("fullrate_bank2", got.romaddr, 6'h15);
        div_mode = 1'b1;

        // Reset lands mid-write; the access ends while reset is held.
        do_reset();
        @(negedge clk);
        ab = 16'h7000; db = 8'h2A; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (wrrq0) pulses++;
            @(negedge clk);
        end
        chk("abort_no_pulse", pulses, 0);
        do_read(16'h6000, got, rdrq);
        chk("abort_bank1", got.romaddr, 6'h01);

        // SCC-only instance ignores the mode register but still takes bank3 writes.
        do_reset();
        do_write(16'hBFFE, 8'hFF, pulses, we_n);
        chk("noplus_mode", mode1, 8'h00);
        chk("plus_mode", mode0, 8'hFF);
        do_write(16'hB000, 8'hFF, pulses, we_n);
        @(negedge clk);
        ab = 16'hA000; cs_n = 1'b0; rd_n = 1'b0;
        #2;
        chk("noplus_bank3", romaddr1, 6'h3F);
        chk("plus_bank3_ram", romaddr0, 6'h03);
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
